// File: rtl/filter_pkg.sv
// filter_pkg: shared definitions for the 3x3 filter pipeline.
// Holds the frame-sequencer state type, default frame geometry and the
// kernel-id width used by the scheduler and the convolution stage.
package filter_pkg;

  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 240;
  localparam int KID_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/filter_border_clean.sv
// filter_border_clean: one-cycle registered stage that zeroes pixels on the
// outer border of the frame, where the 3x3 window reaches outside the image.
// Ports:
//   clk_in, rst_in            pixel clock, async active-high reset
//   filt_valid/pixel/hcount/vcount_in   filter output stream
//   valid/pixel/hcount/vcount_out       cleaned stream, 1 cycle later
module filter_border_clean
  import filter_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        filt_valid_in,
  input  logic [15:0] filt_pixel_in,
  input  logic [10:0] filt_hcount_in,
  input  logic [9:0]  filt_vcount_in,
  output logic        valid_out,
  output logic [15:0] pixel_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  logic        border;
  logic [15:0] pixel_d;

  assign border = (filt_hcount_in == 11'd0) || (filt_hcount_in == H_LAST) ||
                  (filt_vcount_in == 10'd0) || (filt_vcount_in == V_LAST);
  assign pixel_d = border ? 16'h0000 : filt_pixel_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out  <= 1'b0;
      pixel_out  <= 16'h0000;
      hcount_out <= 11'd0;
      vcount_out <= 10'd0;
    end else begin
      valid_out  <= filt_valid_in;
      pixel_out  <= pixel_d;
      hcount_out <= filt_hcount_in;
      vcount_out <= filt_vcount_in;
    end
  end

endmodule

// File: rtl/filter_sched.sv
// filter_sched: frame-synchronous controller for the 3x3 filter pipeline.
// Latches kernel/enable requests and applies them only at start of frame,
// primes the line buffers for two lines after enable, drives kernel select
// and bypass, counts frames and cleans the filtered stream's border.
// Ports:
//   clk_in, rst_in                      pixel clock, async active-high reset
//   cam_valid/hcount/vcount_in          upstream stream (SOF and line ends)
//   enable_req_in                       level, desired filter enable
//   kernel_req_valid_in/id_in           kernel change request strobe
//   filt_*_in                           filter output stream
//   k_select_out, bypass_out            pipeline controls
//   pending_out, state_out, frame_count_out   status
//   valid/pixel/hcount/vcount_out       cleaned stream
//
// state | meaning
// IDLE  | filter off, raw stream bypassed; waits for SOF with enable
// PRIME | line buffers filling; bypassed until two upstream lines seen
// RUN   | filtered stream selected; leaves at SOF with enable low
module filter_sched
  import filter_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int NUM_KERNELS = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cam_valid_in,
  input  logic [10:0]      cam_hcount_in,
  input  logic [9:0]       cam_vcount_in,
  input  logic             enable_req_in,
  input  logic             kernel_req_valid_in,
  input  logic [KID_W-1:0] kernel_req_id_in,
  input  logic             filt_valid_in,
  input  logic [15:0]      filt_pixel_in,
  input  logic [10:0]      filt_hcount_in,
  input  logic [9:0]       filt_vcount_in,
  output logic [KID_W-1:0] k_select_out,
  output logic             bypass_out,
  output logic             pending_out,
  output logic [1:0]       state_out,
  output logic [15:0]      frame_count_out,
  output logic             valid_out,
  output logic [15:0]      pixel_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out
);

  localparam logic [10:0]  H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [KID_W:0] NUM_K = (KID_W + 1)'(NUM_KERNELS);

  state_e           state_q, state_d;
  logic [1:0]       line_q, line_d;
  logic             pend_q, pend_d;
  logic [KID_W-1:0] pend_id_q, pend_id_d;
  logic [KID_W-1:0] ksel_q, ksel_d;
  logic             bypass_q;
  logic [15:0]      fc_q;

  logic sof, line_end, req_ok;

  assign sof      = cam_valid_in && (cam_hcount_in == 11'd0) && (cam_vcount_in == 10'd0);
  assign line_end = cam_valid_in && (cam_hcount_in == H_LAST);
  assign req_ok   = kernel_req_valid_in && ({1'b0, kernel_req_id_in} < NUM_K);

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    case (state_q)
      ST_IDLE: begin
        if (sof && enable_req_in) begin
          state_d = ST_PRIME;
          line_d  = 2'd0;
        end
      end
      ST_PRIME: begin
        // an SOF with enable still high is ignored: priming keeps counting
        if (sof && !enable_req_in) begin
          state_d = ST_IDLE;
          line_d  = 2'd0;
        end else if (line_end) begin
          if (line_q == 2'd1) begin
            state_d = ST_RUN;
            line_d  = 2'd0;
          end else begin
            line_d = line_q + 2'd1;
          end
        end
      end
      ST_RUN: begin
        if (sof && !enable_req_in) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 2'd0;
      end
    endcase
  end

  // A request in the SOF cycle must survive the SOF, so the set wins
  // over the clear and the SOF applies only the previously latched id.
  always_comb begin
    pend_d    = pend_q;
    pend_id_d = pend_id_q;
    ksel_d    = ksel_q;
    if (sof && pend_q) begin
      ksel_d = pend_id_q;
      pend_d = 1'b0;
    end
    if (req_ok) begin
      pend_d    = 1'b1;
      pend_id_d = kernel_req_id_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      line_q    <= 2'd0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      ksel_q    <= '0;
      bypass_q  <= 1'b1;
      fc_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      ksel_q    <= ksel_d;
      bypass_q  <= (state_d != ST_RUN);
      if (sof) fc_q <= fc_q + 16'd1;
    end
  end

  assign k_select_out    = ksel_q;
  assign bypass_out      = bypass_q;
  assign pending_out     = pend_q;
  assign state_out       = state_q;
  assign frame_count_out = fc_q;

  filter_border_clean #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_clean (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .filt_valid_in  (filt_valid_in),
    .filt_pixel_in  (filt_pixel_in),
    .filt_hcount_in (filt_hcount_in),
    .filt_vcount_in (filt_vcount_in),
    .valid_out      (valid_out),
    .pixel_out      (pixel_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out)
  );

endmodule

// File: tb/tb_filter_sched.sv
module tb_filter_sched;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cam_valid_in;
  logic [10:0] cam_hcount_in;
  logic [9:0]  cam_vcount_in;
  logic        enable_req_in;
  logic        kernel_req_valid_in;
  logic [2:0]  kernel_req_id_in;
  logic        filt_valid_in;
  logic [15:0] filt_pixel_in;
  logic [10:0] filt_hcount_in;
  logic [9:0]  filt_vcount_in;
  logic [2:0]  k_select_out;
  logic        bypass_out;
  logic        pending_out;
  logic [1:0]  state_out;
  logic [15:0] frame_count_out;
  logic        valid_out;
  logic [15:0] pixel_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  filter_sched dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .cam_valid_in        (cam_valid_in),
    .cam_hcount_in       (cam_hcount_in),
    .cam_vcount_in       (cam_vcount_in),
    .enable_req_in       (enable_req_in),
    .kernel_req_valid_in (kernel_req_valid_in),
    .kernel_req_id_in    (kernel_req_id_in),
    .filt_valid_in       (filt_valid_in),
    .filt_pixel_in       (filt_pixel_in),
    .filt_hcount_in      (filt_hcount_in),
    .filt_vcount_in      (filt_vcount_in),
    .k_select_out        (k_select_out),
    .bypass_out          (bypass_out),
    .pending_out         (pending_out),
    .state_out           (state_out),
    .frame_count_out     (frame_count_out),
    .valid_out           (valid_out),
    .pixel_out           (pixel_out),
    .hcount_out          (hcount_out),
    .vcount_out          (vcount_out)
  );

  typedef struct {
    logic        fv;
    logic [15:0] pix;
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] exp_pix;
  } vec_t;

  typedef struct {
    logic        fv;
    logic [15:0] pix;
    logic [10:0] h;
    logic [9:0]  v;
  } obs_t;

  obs_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cam_px(input int h, input int v);
    cam_valid_in  = 1'b1;
    cam_hcount_in = 11'(h);
    cam_vcount_in = 10'(v);
    tick();
    cam_valid_in  = 1'b0;
  endtask

  task automatic kreq(input int id, input bit with_sof);
    kernel_req_valid_in = 1'b1;
    kernel_req_id_in    = 3'(id);
    if (with_sof) begin
      cam_valid_in  = 1'b1;
      cam_hcount_in = 11'd0;
      cam_vcount_in = 10'd0;
    end
    tick();
    kernel_req_valid_in = 1'b0;
    cam_valid_in        = 1'b0;
  endtask

  task automatic chk_ctrl(input string tag, input int st, input int byp,
                          input int ks, input int pend, input int fc);
    chk({tag, ".state"},   int'(state_out), st);
    chk({tag, ".bypass"},  int'(bypass_out), byp);
    chk({tag, ".ksel"},    int'(k_select_out), ks);
    chk({tag, ".pending"}, int'(pending_out), pend);
    chk({tag, ".fcount"},  int'(frame_count_out), fc);
  endtask

  vec_t vecs[10];

  initial begin
    obs_t o;
    vecs[0] = '{1'b1, 16'hFFFF, 11'd0,   10'd5,   16'h0000};
    vecs[1] = '{1'b1, 16'hFFFF, 11'd319, 10'd5,   16'h0000};
    vecs[2] = '{1'b1, 16'hFFFF, 11'd5,   10'd0,   16'h0000};
    vecs[3] = '{1'b1, 16'hFFFF, 11'd5,   10'd239, 16'h0000};
    vecs[4] = '{1'b1, 16'hFFFF, 11'd1,   10'd1,   16'hFFFF};
    vecs[5] = '{1'b1, 16'hFFFF, 11'd318, 10'd238, 16'hFFFF};
    vecs[6] = '{1'b0, 16'hABCD, 11'd2,   10'd2,   16'hABCD};
    vecs[7] = '{1'b1, 16'hFFFF, 11'd160, 10'd120, 16'hFFFF};
    vecs[8] = '{1'b1, 16'hFFFF, 11'd319, 10'd239, 16'h0000};
    vecs[9] = '{1'b1, 16'h1234, 11'd320, 10'd5,   16'h1234};

    rst_in = 1'b1;
    cam_valid_in = 1'b0; cam_hcount_in = '0; cam_vcount_in = '0;
    enable_req_in = 1'b0;
    kernel_req_valid_in = 1'b0; kernel_req_id_in = '0;
    filt_valid_in = 1'b0; filt_pixel_in = '0; filt_hcount_in = '0; filt_vcount_in = '0;
    tick(); tick();
    chk_ctrl("reset", 0, 1, 0, 0, 0);
    chk("reset.valid_out", int'(valid_out), 0);
    chk("reset.pixel_out", int'(pixel_out), 0);
    rst_in = 1'b0;
    tick();

    // two frames with filter disabled
    cam_px(0, 0); tick();
    cam_px(0, 0); tick();
    chk_ctrl("idle2", 0, 1, 0, 0, 2);

    // enable, priming over two upstream lines
    enable_req_in = 1'b1;
    cam_px(0, 0);
    chk_ctrl("prime.sof", 1, 1, 0, 0, 3);
    cam_px(319, 0);
    chk("prime.line0.state", int'(state_out), 1);
    cam_px(100, 1);
    chk("prime.mid.state", int'(state_out), 1);
    cam_px(319, 1);
    chk_ctrl("run", 2, 0, 0, 0, 3);

    // last request wins, applied at next SOF
    kreq(4, 0); tick();
    kreq(2, 0);
    chk_ctrl("kreq.pend", 2, 0, 0, 1, 3);
    cam_px(0, 0);
    chk_ctrl("kreq.apply", 2, 0, 2, 0, 4);

    // request in the SOF cycle waits for the following SOF
    kreq(3, 1);
    chk_ctrl("sofreq", 2, 0, 2, 1, 5);
    cam_px(0, 0);
    chk_ctrl("sofreq.apply", 2, 0, 3, 0, 6);

    // id boundary, then disable with kernel applied on the same SOF
    kreq(6, 0);
    chk("kreq6.pending", int'(pending_out), 0);
    kreq(5, 0);
    chk("kreq5.pending", int'(pending_out), 1);
    enable_req_in = 1'b0;
    cam_px(0, 0);
    chk_ctrl("disable", 0, 1, 5, 0, 7);

    // PRIME abort on SOF with enable low, then SOF inside PRIME keeps count
    enable_req_in = 1'b1;
    cam_px(0, 0);
    chk("reprime.state", int'(state_out), 1);
    enable_req_in = 1'b0;
    cam_px(0, 0);
    chk("abort.state", int'(state_out), 0);
    enable_req_in = 1'b1;
    cam_px(0, 0);
    cam_px(319, 0);
    cam_px(0, 0);
    chk("prime.sof2.state", int'(state_out), 1);
    cam_px(319, 1);
    chk_ctrl("run2", 2, 0, 5, 0, 11);

    // border cleaning through a scoreboard
    for (int i = 0; i < 10; i++) begin
      filt_valid_in  = vecs[i].fv;
      filt_pixel_in  = vecs[i].pix;
      filt_hcount_in = vecs[i].h;
      filt_vcount_in = vecs[i].v;
      sb_q.push_back('{vecs[i].fv, vecs[i].exp_pix, vecs[i].h, vecs[i].v});
      #1;
      if (i > 0) begin
        chk("lat.pixel", int'(pixel_out), int'(vecs[i-1].exp_pix));
        chk("lat.hcount", int'(hcount_out), int'(vecs[i-1].h));
      end
      @(posedge clk_in); #1;
      if (sb_q.size() == 0) begin
        chk("sb.empty", 0, 1);
      end else begin
        o = sb_q.pop_front();
        chk("clean.valid", int'(valid_out), int'(o.fv));
        chk("clean.pixel", int'(pixel_out), int'(o.pix));
        chk("clean.hcount", int'(hcount_out), int'(o.h));
        chk("clean.vcount", int'(vcount_out), int'(o.v));
      end
    end
    filt_valid_in = 1'b0;
    tick();
    chk("clean.valid_drop", int'(valid_out), 0);

    // asynchronous reset mid-frame in RUN
    filt_valid_in = 1'b1; filt_pixel_in = 16'h1234;
    filt_hcount_in = 11'd100; filt_vcount_in = 10'd50;
    cam_px(100, 50);
    chk("prerst.valid_out", int'(valid_out), 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk_ctrl("asyncrst", 0, 1, 0, 0, 0);
    chk("asyncrst.valid_out", int'(valid_out), 0);
    chk("asyncrst.pixel_out", int'(pixel_out), 0);
    chk("asyncrst.hcount_out", int'(hcount_out), 0);
    filt_valid_in = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    tick();
    kreq(7, 0);
    chk_ctrl("postrst.req7", 0, 1, 0, 0, 0);

    // frame counter wrap: every cycle an SOF, enable low
    enable_req_in = 1'b0;
    cam_valid_in = 1'b1; cam_hcount_in = '0; cam_vcount_in = '0;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk_in);
    end
    #1;
    chk("wrap.max", int'(frame_count_out), 65535);
    tick();
    chk("wrap.zero", int'(frame_count_out), 0);
    cam_valid_in = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
